// File: rtl/invsubbytes_seq.sv
// invsubbytes_seq: AES inverse SubBytes stage with valid/ready handshakes on both sides.
// Default build runs four inverse S-boxes over the state one 32-bit word per cycle.
// Defining ISB_PARALLEL_EN builds sixteen inverse S-boxes instead. The whole state is
// then substituted on the accept edge, and one block per cycle is possible.
//
// state | meaning
// IDLE  | no block held, ready for input
// RUN   | substituting word cnt_q of the held state (sequential build only)
// DONE  | result on op with out_valid high, waiting for out_ready
module invsubbytes_seq #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           ip,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           op,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic [127:0]           data_q;
  logic                   out_valid_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic [31:0]  word_sel;
  logic [31:0]  sub_word;
  logic [127:0] data_wb;
  logic         accept;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map first, then invert in GF(2^8).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

`ifdef ISB_PARALLEL_EN
  function automatic logic [127:0] inv_sub_state(input logic [127:0] s);
    return {inv_sub_word(s[127:96]), inv_sub_word(s[95:64]),
            inv_sub_word(s[63:32]), inv_sub_word(s[31:0])};
  endfunction
`endif

  assign accept = in_valid & in_ready;

  // Select the current word, substitute it, and write it back in place.
  always_comb begin
    word_sel = data_q[127:96];
    data_wb  = data_q;
    case (cnt_q)
      2'd1:    word_sel = data_q[95:64];
      2'd2:    word_sel = data_q[63:32];
      2'd3:    word_sel = data_q[31:0];
      default: word_sel = data_q[127:96];
    endcase
    sub_word = inv_sub_word(word_sel);
    case (cnt_q)
      2'd1:    data_wb[95:64]  = sub_word;
      2'd2:    data_wb[63:32]  = sub_word;
      2'd3:    data_wb[31:0]   = sub_word;
      default: data_wb[127:96] = sub_word;
    endcase
  end

  // Sequencing FSM with registered result, out_valid and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ISB_PARALLEL_EN
            data_q      <= inv_sub_state(ip);
            state_q     <= DONE;
            out_valid_q <= 1'b1;
`else
            data_q      <= ip;
            cnt_q       <= 2'd0;
            state_q     <= RUN;
            out_valid_q <= 1'b0;
`endif
          end else if ((state_q == DONE) && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        RUN: begin
          data_q <= data_wb;
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A finished result is handed over on the same edge that takes the next block.
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign op        = data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign stall_cnt = stall_q;

endmodule
